hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4, meaning the maximum number of long-latency writes in flight (range 1..31).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rs1_id / rs2_id, input, 5 each, ID-stage source registers.
REQ-005 SHALL have ports rs1_used_id / rs2_used_id, input, 1 each, source is actually read.
REQ-006 SHALL have ports rd_id, input, 5, and reg_write_id, input, 1, ID-stage destination and write enable.
REQ-007 SHALL have port long_op_id, input, 1, meaning the ID instruction is long-latency (div/rem/uncached load).
REQ-008 SHALL have port valid_id, input, 1, ID holds a real instruction.
REQ-009 SHALL have port flush_id, input, 1, ID instruction is being squashed this cycle.
REQ-010 SHALL have ports rd_exe, input, 5, and mem_read_exe, input, 1, the EXE load destination for load-use detection.
REQ-011 SHALL have ports wb_long_valid, input, 1, and wb_long_rd, input, 5, the completion of a long op at WB.
REQ-012 SHALL have port stall_id, output, 1, hold IF/ID and insert a bubble into EXE.
REQ-013 SHALL have port busy_vec, output, 32, the registered per-register pending-write bits.
REQ-014 SHALL have port pending_cnt, output, 5, the registered count of in-flight long ops.
REQ-015 SHALL have port err_spurious, output, 1, a sticky flag for completion to a non-busy register.

Function
REQ-016 stall_id SHALL be combinational and asserted only when valid_id=1 and flush_id=0 and any of the following holds:
- RAW-long: a used rsN is nonzero and busy_vec[rsN]=1, and not (wb_long_valid and wb_long_rd==rsN);
- load-use: mem_read_exe=1, rd_exe!=0, and a used rsN==rd_exe;
- WAW: reg_write_id=1, rd_id!=0, busy_vec[rd_id]=1, and not cleared this cycle;
- full: long_op_id=1, reg_write_id=1, and pending_cnt==MAX_PENDING with no completion this cycle.
REQ-017 Issue SHALL be the condition valid_id and ~flush_id and ~stall_id and long_op_id and reg_write_id and rd_id!=0.
REQ-018 On issue, busy_vec[rd_id] SHALL be set at the next edge and pending_cnt SHALL increment.
REQ-019 A valid completion (wb_long_valid=1 with busy_vec[wb_long_rd]=1) SHALL clear that bit at the next edge and decrement pending_cnt.
REQ-020 Issue and completion in the same cycle SHALL update both; for the same register, set wins and pending_cnt is unchanged.
REQ-021 A completion with wb_long_rd=0 or with the bit clear SHALL change no state and SHALL set err_spurious at the next edge.
REQ-022 busy_vec[0] SHALL always read 0; register x0 never causes a stall.
REQ-023 Non-long writes SHALL never set busy bits; their hazards are covered by forwarding and load-use detection.
REQ-024 flush_id SHALL NOT clear existing busy bits; issued long ops always complete through WB.
REQ-025 pending_cnt SHALL equal popcount(busy_vec) at every edge.
REQ-026 pending_cnt SHALL never exceed MAX_PENDING and SHALL never underflow.

Reset
REQ-027 While reset=1, busy_vec SHALL be 0, pending_cnt SHALL be 0, and err_spurious SHALL be 0, asynchronously.
REQ-028 While reset=1, stall_id SHALL be 0 because no busy bits are set; inputs received during reset SHALL be ignored.
REQ-029 Reset mid-operation SHALL drop all pending entries; late completions after reset SHALL raise err_spurious.

Structure
REQ-030 The shared core package SHALL hold REG_ADDR_W=5, NUM_REGS=32, and the register-index typedef.
REQ-031 One sub-module, scoreboard_hazard_cmp, SHALL implement the per-source RAW/load-use compare and be instantiated twice (rs1, rs2).

Verification
REQ-032 Issue a div with rd=5; next cycle ID reads rs1=5 -> stall_id=1 until the cycle wb_long_rd=5 completes, when stall_id=0 and bit 5 clears at the edge.
REQ-033 Load in EXE with rd_exe=7 while ID uses rs2=7 -> stall_id=1 for exactly one cycle; with rs2_used_id=0 -> stall_id=0.
REQ-034 Issue 4 long ops to rd=1,2,3,4 (MAX_PENDING=4), then a 5th long op -> stall_id=1 and pending_cnt=4; completing rd=2 in the same cycle -> issue proceeds and pending_cnt stays 4.
REQ-035 Same-cycle issue rd=9 and completion rd=9, with bit 9 previously set and ID not reading x9 -> bit 9 remains 1 and pending_cnt is unchanged.
REQ-036 Completion wb_long_rd=12 with bit 12 clear -> err_spurious=1 sticky and busy_vec unchanged; reset -> err_spurious=0.
REQ-037 Long op with rd=0, and any rs=0 -> no busy bit set and stall_id=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the long-latency write hazard scoreboard.
// Register-file geometry, the register index type and the in-flight counter width.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int CNT_W      = 5;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   // x0 is hardwired to zero, so it never carries a dependency.
   function automatic logic reg_nz(input reg_idx_t r);
      return (r != '0);
   endfunction

endpackage

// File: rtl/scoreboard_hazard_cmp.sv
// Per-source hazard compare: RAW against a pending long-latency write,
// or load-use against the load currently in EXE.
module scoreboard_hazard_cmp
   import hazard_scoreboard_pkg::*;
(
   input  logic [NUM_REGS-1:0] busy_vec,
   input  reg_idx_t            rs,
   input  logic                rs_used,
   input  logic                mem_read_exe,
   input  reg_idx_t            rd_exe,
   input  logic                wb_long_valid,
   input  reg_idx_t            wb_long_rd,
   output logic                hazard
);

   logic raw_long;
   logic load_use;

   // A completion arriving this cycle releases the source in time to be read.
   assign raw_long = rs_used && reg_nz(rs) && busy_vec[rs] &&
                     !(wb_long_valid && (wb_long_rd == rs));

   assign load_use = rs_used && mem_read_exe && reg_nz(rd_exe) && (rs == rd_exe);

   assign hazard = raw_long || load_use;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks registers with long-latency writes in flight
// and raises stall_id on RAW, WAW, load-use and full-tracker conditions.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned MAX_PENDING = 4
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [REG_ADDR_W-1:0] rd_id,
   input  logic                  reg_write_id,
   input  logic                  long_op_id,
   input  logic                  valid_id,
   input  logic                  flush_id,
   input  logic [REG_ADDR_W-1:0] rd_exe,
   input  logic                  mem_read_exe,
   input  logic                  wb_long_valid,
   input  logic [REG_ADDR_W-1:0] wb_long_rd,
   output logic                  stall_id,
   output logic [NUM_REGS-1:0]   busy_vec,
   output logic [CNT_W-1:0]      pending_cnt,
   output logic                  err_spurious
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

   logic                haz_rs1;
   logic                haz_rs2;
   logic                waw;
   logic                full;
   logic                comp_valid;
   logic                comp_bad;
   logic                active;
   logic                issue;
   logic [NUM_REGS-1:0] busy_next;
   logic [CNT_W-1:0]    cnt_next;

   scoreboard_hazard_cmp u_cmp_rs1 (
      .busy_vec      (busy_vec),
      .rs            (rs1_id),
      .rs_used       (rs1_used_id),
      .mem_read_exe  (mem_read_exe),
      .rd_exe        (rd_exe),
      .wb_long_valid (wb_long_valid),
      .wb_long_rd    (wb_long_rd),
      .hazard        (haz_rs1)
   );

   scoreboard_hazard_cmp u_cmp_rs2 (
      .busy_vec      (busy_vec),
      .rs            (rs2_id),
      .rs_used       (rs2_used_id),
      .mem_read_exe  (mem_read_exe),
      .rd_exe        (rd_exe),
      .wb_long_valid (wb_long_valid),
      .wb_long_rd    (wb_long_rd),
      .hazard        (haz_rs2)
   );

   // busy_vec[0] is never set, so a completion to x0 is always spurious.
   assign comp_valid = wb_long_valid && busy_vec[wb_long_rd];
   assign comp_bad   = wb_long_valid && !comp_valid;

   assign waw  = reg_write_id && reg_nz(rd_id) && busy_vec[rd_id] &&
                 !(wb_long_valid && (wb_long_rd == rd_id));
   assign full = long_op_id && reg_write_id && (pending_cnt == MAX_CNT) && !comp_valid;

   // Inputs seen while reset is held must not produce a stall.
   assign active   = valid_id && !flush_id && !reset;
   assign stall_id = active && (haz_rs1 || haz_rs2 || waw || full);
   assign issue    = active && !(haz_rs1 || haz_rs2 || waw || full) &&
                     long_op_id && reg_write_id && reg_nz(rd_id);

   // Clear before set so a same-register issue/completion leaves the bit busy.
   always_comb begin
      busy_next = busy_vec;
      if (comp_valid)
         busy_next[wb_long_rd] = 1'b0;
      if (issue)
         busy_next[rd_id] = 1'b1;
      busy_next[0] = 1'b0;

      cnt_next = pending_cnt;
      if (issue && !comp_valid)
         cnt_next = pending_cnt + CNT_W'(1);
      else if (!issue && comp_valid)
         cnt_next = pending_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_vec     <= '0;
         pending_cnt  <= '0;
         err_spurious <= 1'b0;
      end else begin
         busy_vec    <= busy_next;
         pending_cnt <= cnt_next;
         if (comp_bad)
            err_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, checked
// cycle by cycle against a register-set model through an expected-value queue.
module tb_hazard_scoreboard;

   localparam int MAXP = 4;
   localparam int W    = 39;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rs1_id = '0, rs2_id = '0, rd_id = '0, rd_exe = '0, wb_long_rd = '0;
   logic        rs1_used_id = 1'b0, rs2_used_id = 1'b0, reg_write_id = 1'b0;
   logic        long_op_id = 1'b0, valid_id = 1'b0, flush_id = 1'b0;
   logic        mem_read_exe = 1'b0, wb_long_valid = 1'b0;
   logic        stall_id;
   logic [31:0] busy_vec;
   logic [4:0]  pending_cnt;
   logic        err_spurious;

   bit          m_busy [32];
   bit          m_err;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp, mon_act;
   int          n_cmp = 0;
   int          n_bad = 0;

   hazard_scoreboard #(.MAX_PENDING(MAXP)) dut (
      .clk           (clk),
      .reset         (reset),
      .rs1_id        (rs1_id),
      .rs2_id        (rs2_id),
      .rs1_used_id   (rs1_used_id),
      .rs2_used_id   (rs2_used_id),
      .rd_id         (rd_id),
      .reg_write_id  (reg_write_id),
      .long_op_id    (long_op_id),
      .valid_id      (valid_id),
      .flush_id      (flush_id),
      .rd_exe        (rd_exe),
      .mem_read_exe  (mem_read_exe),
      .wb_long_valid (wb_long_valid),
      .wb_long_rd    (wb_long_rd),
      .stall_id      (stall_id),
      .busy_vec      (busy_vec),
      .pending_cnt   (pending_cnt),
      .err_spurious  (err_spurious)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model
   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic bit src_haz(input logic [4:0] rs, input logic used);
      if (!used) return 1'b0;
      if (rs != 0 && m_busy[rs] && !(wb_long_valid && wb_long_rd == rs)) return 1'b1;
      if (mem_read_exe && rd_exe != 0 && rs == rd_exe) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_stall();
      bit done_ok;
      if (reset || !valid_id || flush_id) return 1'b0;
      done_ok = wb_long_valid && wb_long_rd != 0 && m_busy[wb_long_rd];
      if (src_haz(rs1_id, rs1_used_id) || src_haz(rs2_id, rs2_used_id)) return 1'b1;
      if (reg_write_id && rd_id != 0 && m_busy[rd_id] &&
          !(wb_long_valid && wb_long_rd == rd_id)) return 1'b1;
      if (long_op_id && reg_write_id && m_count() == MAXP && !done_ok) return 1'b1;
      return 1'b0;
   endfunction

   // driver tasks: called at posedge+1, push this cycle's expectation, advance model
   task automatic cyc();
      logic [31:0] bv;
      bit st, issue;
      if (reset) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_err = 1'b0;
      end
      st = m_stall();
      for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
      exp_q.push_back({st, bv, 5'(m_count()), m_err});
      if (!reset) begin
         issue = valid_id && !flush_id && !st && long_op_id && reg_write_id && rd_id != 0;
         if (wb_long_valid) begin
            if (wb_long_rd != 0 && m_busy[wb_long_rd]) m_busy[wb_long_rd] = 1'b0;
            else m_err = 1'b1;
         end
         if (issue) m_busy[rd_id] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1_id = 0; rs2_id = 0; rd_id = 0; rd_exe = 0; wb_long_rd = 0;
      rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0; long_op_id = 0;
      valid_id = 0; flush_id = 0; mem_read_exe = 0; wb_long_valid = 0;
   endtask

   task automatic long_op(input logic [4:0] rd);
      idle();
      valid_id = 1; long_op_id = 1; reg_write_id = 1; rd_id = rd;
   endtask

   task automatic complete(input logic [4:0] rd);
      idle();
      wb_long_valid = 1; wb_long_rd = rd;
      cyc();
   endtask

   task automatic rand_cycle();
      int bl[$];
      idle();
      reset        = ($urandom_range(0, 199) == 0);
      valid_id     = ($urandom_range(0, 9) != 0);
      flush_id     = ($urandom_range(0, 15) == 0);
      rs1_id       = 5'($urandom_range(0, 7));
      rs2_id       = 5'($urandom_range(0, 7));
      rd_id        = 5'($urandom_range(0, 7));
      rs1_used_id  = 1'($urandom_range(0, 1));
      rs2_used_id  = 1'($urandom_range(0, 1));
      reg_write_id = ($urandom_range(0, 3) != 0);
      long_op_id   = ($urandom_range(0, 4) < 2);
      mem_read_exe = ($urandom_range(0, 4) == 0);
      rd_exe       = 5'($urandom_range(0, 7));
      for (int i = 0; i < 32; i++) if (m_busy[i]) bl.push_back(i);
      if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
         wb_long_valid = 1;
         wb_long_rd    = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      end else if ($urandom_range(0, 49) == 0) begin
         wb_long_valid = 1;
         wb_long_rd    = 5'($urandom_range(0, 7));
      end
      cyc();
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {stall_id, busy_vec, pending_cnt, err_spurious};
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_bad++;
            $display("FAIL cycle t=%0t got stall=%b busy=%h cnt=%0d err=%b exp stall=%b busy=%h cnt=%0d err=%b",
                     $time, mon_act[38], mon_act[37:6], mon_act[5:1], mon_act[0],
                     mon_exp[38], mon_exp[37:6], mon_exp[5:1], mon_exp[0]);
         end
      end
   end

   initial begin
      idle();
      @(posedge clk);
      #1;
      cyc(); cyc();
      reset = 0;
      cyc();

      // long op rd=5, dependent read stalls until completion to x5
      long_op(5); cyc();
      idle(); valid_id = 1; rs1_id = 5; rs1_used_id = 1;
      cyc(); cyc(); cyc();
      wb_long_valid = 1; wb_long_rd = 5; cyc();
      idle(); cyc();

      // load-use on rs2, then with rs2 unused
      idle(); valid_id = 1; rs2_id = 7; rs2_used_id = 1; mem_read_exe = 1; rd_exe = 7; cyc();
      mem_read_exe = 0; cyc();
      mem_read_exe = 1; rs2_used_id = 0; cyc();

      // fill the tracker, stall the fifth, then issue alongside a completion
      for (int r = 1; r <= 4; r++) begin long_op(5'(r)); cyc(); end
      long_op(6); cyc(); cyc();
      wb_long_valid = 1; wb_long_rd = 2; cyc();
      complete(1); complete(3); complete(4); complete(6);

      // same-register issue and completion
      long_op(9); cyc();
      long_op(9); wb_long_valid = 1; wb_long_rd = 9; cyc();
      idle(); cyc();
      complete(9);

      // x0 destination and sources
      long_op(0); rs1_id = 0; rs2_id = 0; rs1_used_id = 1; rs2_used_id = 1; cyc();
      idle(); cyc();

      // spurious completion is sticky until reset
      complete(12);
      idle(); cyc(); cyc();
      reset = 1; cyc();
      reset = 0; cyc();

      // reset mid-operation, then a late completion
      long_op(3); cyc();
      long_op(4); cyc();
      idle(); reset = 1; cyc();
      reset = 0; cyc();
      complete(3);
      idle(); reset = 1; cyc();
      reset = 0; cyc();

      for (int n = 0; n < 2000; n++) rand_cycle();
      reset = 0;
      idle(); cyc();

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d left exp 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL timeout got t=%0t exp finish before 500000", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
